ifu_icache_sa: RTL and testbench

Parametrised set-associative instruction cache for the IFU, generalising the fixed 32KB/2-way/2-bank icache in ways, sets, line size and fetch width.
- Accepts one fetch request per cycle on hits.
- Refills misses from the L2/bus over a beat-serial memory port.
- Supports a whole-cache invalidate (fence.i).
- Sits between the IFU fetch-address stage and the memory interface.

---
 rtl/ifu_icache_pkg.sv | 24 ++
 rtl/ifu_icache_victim.sv | 22 ++
 rtl/ifu_icache_sa.sv | 178 +++++++++++++++++
 tb/tb_ifu_icache_sa.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ifu_icache_pkg.sv
// ifu_icache_pkg: FSM state type, default geometry and address-split helpers for ifu_icache_sa
package ifu_icache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, FLUSH} ic_state_e;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_FETCH_W = 128;
  localparam int DEF_LINE_BYTES = 32;
  localparam int DEF_SETS = 512;
  localparam int DEF_WAYS = 2;
  function automatic int offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction
  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
    return addr_w - $clog2(sets) - $clog2(line_bytes);
  endfunction
  function automatic int beats(input int line_bytes, input int fetch_w);
    return line_bytes * 8 / fetch_w;
  endfunction
  function automatic int min1_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ifu_icache_victim.sv
// ifu_icache_victim: replacement choice for one set
// Ports: valid_i per-way valid bits, rr_i round-robin pointer of the set,
//        victim_o chosen way, rr_adv_o high when the victim came from rr_i.
module ifu_icache_victim
  import ifu_icache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS,
  localparam int WAY_W = min1_w(WAYS)
) (
  input  logic [WAYS-1:0]  valid_i,
  input  logic [WAY_W-1:0] rr_i,
  output logic [WAY_W-1:0] victim_o,
  output logic             rr_adv_o
);
  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    victim_o = rr_i;
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid_i[i]) victim_o = WAY_W'(i);
  end
  assign rr_adv_o = &valid_i;
endmodule

// File: rtl/ifu_icache_sa.sv
// ifu_icache_sa: parametrised set-associative instruction cache with beat-serial refill
// Ports: clk/rst (async, active-low); req_* fetch request in, resp_* one-cycle
//        response out; flush_req/flush_busy whole-cache invalidate; mem_req_* line
//        refill request out; mem_rsp_* refill beats in, ascending order.
module ifu_icache_sa
  import ifu_icache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FETCH_W = DEF_FETCH_W,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int SETS = DEF_SETS,
  parameter int WAYS = DEF_WAYS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               resp_valid,
  output logic [FETCH_W-1:0] resp_data,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [FETCH_W-1:0] mem_rsp_data
);
  localparam int OFFSET_W = offset_w(LINE_BYTES);
  localparam int INDEX_W = index_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_BYTES);
  localparam int BEATS = beats(LINE_BYTES, FETCH_W);
  localparam int BEAT_W = min1_w(BEATS);
  localparam int WAY_W = min1_w(WAYS);
  localparam int BOFF_W = $clog2(FETCH_W / 8);

  ic_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [BEAT_W-1:0] cnt_q;
  logic [WAY_W-1:0] victim_q, vic;
  logic adv_q, rr_adv;
  logic flush_pend_q, flush_pend_d;
  logic [INDEX_W-1:0] fcnt_q;
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAY_W-1:0] rr_q [SETS];
  logic [TAG_W-1:0] tag_arr [SETS][WAYS];
  logic [FETCH_W-1:0] data_arr [SETS][WAYS][BEATS];
  logic [TAG_W-1:0] tag_rd_q [WAYS];
  logic [FETCH_W-1:0] data_rd_q [WAYS];
  logic [WAYS-1:0] hit_vec;
  logic [FETCH_W-1:0] hit_data;
  logic hit, rdy, acc, last, wr_en, rd_en, flush_any;
  logic [ADDR_W-1:0] rd_addr;
  logic [INDEX_W-1:0] idx_q, rd_idx;
  logic [BEAT_W-1:0] rd_beat;
  logic [TAG_W-1:0] tag_q;

  assign idx_q = INDEX_W'(addr_q >> OFFSET_W);
  assign tag_q = TAG_W'(addr_q >> (OFFSET_W + INDEX_W));
  assign flush_any = flush_req || flush_pend_q;
  // req_ready is gated by rst so it reads 0 while reset is held, even though IDLE would otherwise raise it.
  assign req_ready = rdy && rst;
  assign acc = req_valid && req_ready;
  assign wr_en = state_q == REFILL && mem_rsp_valid;
  assign last = wr_en && cnt_q == BEAT_W'(BEATS - 1);
  // The final refill beat re-reads the arrays so the replayed LOOKUP sees the new line.
  assign rd_en = acc || last;
  assign rd_addr = acc ? req_addr : addr_q;
  assign rd_idx = INDEX_W'(rd_addr >> OFFSET_W);
  assign rd_beat = BEAT_W'((rd_addr >> BOFF_W) % ADDR_W'(BEATS));
  assign mem_req_addr = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign resp_data = resp_valid ? hit_data : '0;

  ifu_icache_victim #(.WAYS(WAYS)) u_victim (
    .valid_i (valid_q[idx_q]),
    .rr_i    (rr_q[idx_q]),
    .victim_o(vic),
    .rr_adv_o(rr_adv)
  );

  always_comb begin
    hit_vec = '0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx_q][w] && tag_rd_q[w] == tag_q;
      hit_data |= hit_vec[w] ? data_rd_q[w] : '0;
    end
  end
  assign hit = |hit_vec;

  always_comb begin
    state_d = state_q;
    rdy = 1'b0;
    resp_valid = 1'b0;
    mem_req_valid = 1'b0;
    flush_busy = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = !flush_any;
        state_d = flush_any ? FLUSH : req_valid ? LOOKUP : IDLE;
      end
      LOOKUP: begin
        resp_valid = hit;
        rdy = hit && !flush_any;
        state_d = !hit ? MISS_REQ : flush_any ? FLUSH : req_valid ? LOOKUP : IDLE;
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        state_d = mem_req_ready ? REFILL : MISS_REQ;
      end
      REFILL: state_d = last ? LOOKUP : REFILL;
      FLUSH: begin
        flush_busy = 1'b1;
        state_d = fcnt_q == INDEX_W'(SETS - 1) ? IDLE : FLUSH;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush seen mid-transaction is remembered until the transaction has responded.
  assign flush_pend_d = state_d == FLUSH ? 1'b0 :
    flush_pend_q || (flush_req && (state_q == LOOKUP || state_q == MISS_REQ || state_q == REFILL));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      victim_q <= '0;
      adv_q <= 1'b0;
      flush_pend_q <= 1'b0;
      fcnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      flush_pend_q <= flush_pend_d;
      if (acc) addr_q <= req_addr;
      if (state_q == LOOKUP && !hit) begin
        victim_q <= vic;
        adv_q <= rr_adv;
      end
      if (state_q == MISS_REQ && mem_req_ready) cnt_q <= '0;
      else if (wr_en) cnt_q <= cnt_q + 1'b1;
      if (last) begin
        valid_q[idx_q][victim_q] <= 1'b1;
        if (adv_q) rr_q[idx_q] <= rr_q[idx_q] == WAY_W'(WAYS - 1) ? '0 : rr_q[idx_q] + 1'b1;
      end
      if (state_q == FLUSH) begin
        valid_q[fcnt_q] <= '0;
        rr_q[fcnt_q] <= '0;
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  // SRAM-style arrays: synchronous read, with the line being completed forwarded
  // into the read registers because the write and the replay read share a cycle.
  always_ff @(posedge clk) begin
    if (wr_en) data_arr[idx_q][victim_q][cnt_q] <= mem_rsp_data;
    if (last) tag_arr[idx_q][victim_q] <= tag_q;
    if (rd_en)
      for (int w = 0; w < WAYS; w++) begin
        tag_rd_q[w] <= (last && victim_q == WAY_W'(w)) ? tag_q : tag_arr[rd_idx][w];
        data_rd_q[w] <= (last && victim_q == WAY_W'(w) && rd_beat == cnt_q) ? mem_rsp_data
                                                                           : data_arr[rd_idx][w][rd_beat];
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == LOOKUP) assert ($onehot0(hit_vec)) else $error("ifu_icache_sa: multiple ways hit");
      if (state_q != REFILL) assert (!mem_rsp_valid) else $error("ifu_icache_sa: refill beat outside REFILL");
    end
  end
endmodule

// File: tb/tb_ifu_icache_sa.sv
// tb_ifu_icache_sa: directed self-checking bench for ifu_icache_sa (default geometry, BEATS=2, SETS=512)
module tb_ifu_icache_sa;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [31:0] req_addr = '0;
  logic resp_valid;
  logic [127:0] resp_data;
  logic flush_req = 1'b0;
  logic flush_busy;
  logic mem_req_valid;
  logic mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic mem_rsp_valid = 1'b0;
  logic [127:0] mem_rsp_data = '0;
  int checks = 0;
  int errors = 0;

  localparam logic [127:0] DA = {4{32'hAAAA_0001}};
  localparam logic [127:0] DB = {4{32'hBBBB_0002}};
  localparam logic [127:0] DC = {4{32'hCCCC_0003}};
  localparam logic [127:0] DD = {4{32'hDDDD_0004}};
  localparam logic [127:0] DE = {4{32'hEEEE_0005}};
  localparam logic [127:0] DF = {4{32'hFFFF_0006}};
  localparam logic [127:0] DG = {4{32'h1234_5678}};
  localparam logic [127:0] DH = {4{32'h8765_4321}};

  ifu_icache_sa dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE; on a miss serve the line (beat b0 then b1),
  // optionally pulsing flush_req alongside the first beat.
  task automatic fetch(input string tag, input logic [31:0] a, input logic exp_hit,
                       input logic [127:0] b0, input logic [127:0] b1,
                       input logic [127:0] exp, input logic fl);
    req_valid = 1'b1;
    req_addr = a;
    #1;
    chk({tag, ".accept"}, req_ready, 1);
    step();
    req_valid = 1'b0;
    #1;
    chk({tag, ".hit"}, resp_valid, exp_hit);
    if (exp_hit) begin
      chk({tag, ".hitdata"}, resp_data, exp);
      step();
    end else begin
      step();
      #1;
      chk({tag, ".memvalid"}, mem_req_valid, 1);
      chk({tag, ".memaddr"}, mem_req_addr, a & 32'hFFFF_FFE0);
      step();
      #1;
      chk({tag, ".memhold"}, {mem_req_valid, mem_req_addr}, {1'b1, a & 32'hFFFF_FFE0});
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data = b0;
      flush_req = fl;
      step();
      flush_req = 1'b0;
      mem_rsp_data = b1;
      step();
      mem_rsp_valid = 1'b0;
      #1;
      chk({tag, ".replay"}, {resp_valid, req_ready}, {1'b1, !fl});
      chk({tag, ".filldata"}, resp_data, exp);
      step();
    end
  endtask

  task automatic flush_wait(input string tag);
    int n = 0;
    int bad = 0;
    while (flush_busy && n < 1000) begin
      if (req_ready) bad++;
      n++;
      step();
    end
    chk({tag, ".busycycles"}, n, 512);
    chk({tag, ".readylow"}, bad, 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    step();
    chk("reset.outs", {req_ready, resp_valid, mem_req_valid, flush_busy}, 4'b0000);
    chk("reset.respdata", resp_data, 0);
    chk("reset.memaddr", mem_req_addr, 0);
    step();
    rst = 1'b1;
    // Cold miss then hit on the other beat.
    fetch("cold", 32'h0000_1010, 1'b0, DA, DB, DB, 1'b0);
    fetch("rehit", 32'h0000_1000, 1'b1, '0, '0, DA, 1'b0);
    // Back-to-back hits at one request per cycle.
    req_valid = 1'b1;
    req_addr = 32'h0000_1000;
    step();
    req_addr = 32'h0000_1010;
    #1;
    chk("b2b.1", {req_ready, resp_valid, resp_data}, {2'b11, DA});
    step();
    req_addr = 32'h0000_1000;
    #1;
    chk("b2b.2", {req_ready, resp_valid, resp_data}, {2'b11, DB});
    step();
    req_valid = 1'b0;
    #1;
    chk("b2b.3", {resp_valid, resp_data}, {1'b1, DA});
    step();
    chk("b2b.idle", resp_valid, 0);
    // Three tags on set 0x80: way1 fills invalid first, then rr picks way0.
    fetch("conf.5000", 32'h0000_5000, 1'b0, DC, DD, DC, 1'b0);
    fetch("conf.9000", 32'h0000_9000, 1'b0, DE, DF, DE, 1'b0);
    fetch("conf.5000hit", 32'h0000_5000, 1'b1, '0, '0, DC, 1'b0);
    fetch("conf.1000miss", 32'h0000_1000, 1'b0, DA, DB, DA, 1'b0);
    fetch("conf.9000hit", 32'h0000_9000, 1'b1, '0, '0, DE, 1'b0);
    fetch("conf.5000miss", 32'h0000_5000, 1'b0, DC, DD, DC, 1'b0);
    // Flush arriving mid-refill: response still delivered, then a full flush.
    fetch("flrefill", 32'h0000_2000, 1'b0, DG, DH, DG, 1'b1);
    flush_wait("flrefill");
    fetch("postflush", 32'h0000_1000, 1'b0, DA, DB, DA, 1'b0);
    // Flush and request together in IDLE: flush wins.
    req_valid = 1'b1;
    req_addr = 32'h0000_1000;
    flush_req = 1'b1;
    #1;
    chk("simul.ready", req_ready, 0);
    step();
    flush_req = 1'b0;
    flush_wait("simul");
    fetch("simul.after", 32'h0000_1000, 1'b0, DA, DB, DA, 1'b0);
    // Async reset during the second refill beat.
    req_valid = 1'b1;
    req_addr = 32'h0000_3000;
    step();
    req_valid = 1'b0;
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = DG;
    step();
    mem_rsp_data = DH;
    rst = 1'b0;
    #1;
    chk("rstmid.outs", {req_ready, resp_valid, mem_req_valid, flush_busy}, 4'b0000);
    chk("rstmid.data", {resp_data, mem_req_addr}, 0);
    step();
    mem_rsp_valid = 1'b0;
    rst = 1'b1;
    fetch("rstmid.1000", 32'h0000_1000, 1'b0, DC, DD, DC, 1'b0);
    fetch("rstmid.3010", 32'h0000_3010, 1'b0, DE, DF, DF, 1'b0);
    fetch("rstmid.3000hit", 32'h0000_3000, 1'b1, '0, '0, DE, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
